// File: rtl/proc_pkg.sv
// Shared processor definitions: selective-write codes, default widths and
// writeback FSM encoding.
package proc_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  localparam logic [0:2] PPP_FULL = 3'b000;
  localparam logic [0:2] PPP_HI   = 3'b001;
  localparam logic [0:2] PPP_LO   = 3'b010;
  localparam logic [0:2] PPP_EVEN = 3'b011;
  localparam logic [0:2] PPP_ODD  = 3'b100;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Codes above PPP_ODD are undefined and fall back to a full-width write.
  function automatic logic [0:2] ppp_norm(input logic [0:2] code);
    return (code > PPP_ODD) ? PPP_FULL : code;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage / data-memory / register-file signal bundle seen by the writeback stage.
interface wb_stage_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              mem_valid;
  logic              mem_wb_en;
  logic              mem_is_load;
  logic [0:ADDR_W-1] mem_rd;
  logic [0:2]        mem_ppp;
  logic [0:DATA_W-1] mem_alu_data;
  logic              dmem_rsp_valid;
  logic [0:DATA_W-1] dmem_rsp_data;
  logic              stall_out;
  logic              wr_en;
  logic [0:2]        ppp;
  logic [0:ADDR_W-1] in_addr;
  logic [0:DATA_W-1] in_data;
  logic              err_timeout;

  modport master (
    output mem_valid, mem_wb_en, mem_is_load, mem_rd, mem_ppp, mem_alu_data,
    output dmem_rsp_valid, dmem_rsp_data,
    input  stall_out, wr_en, ppp, in_addr, in_data, err_timeout
  );

  modport slave (
    input  mem_valid, mem_wb_en, mem_is_load, mem_rd, mem_ppp, mem_alu_data,
    input  dmem_rsp_valid, dmem_rsp_data,
    output stall_out, wr_en, ppp, in_addr, in_data, err_timeout
  );
endinterface

// File: rtl/wb_load_timer.sv
// Load-wait cycle counter with terminal-count detect and sticky timeout flag.
module wb_load_timer #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic err
);

  logic [0:CNT_W-1] cnt_q;

  assign tc = (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Error is set only by a waiting cycle that hits terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (en && tc) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results into the register-file write port and
// stalls upstream while a load response is outstanding.
module wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  wb_state_e         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [0:2]        ppp_q, ppp_d;
  logic [0:ADDR_W-1] addr_q, addr_d;
  logic [0:DATA_W-1] data_q, data_d;
  logic              ld_wb_q, ld_wb_d;
  logic [0:ADDR_W-1] ld_rd_q, ld_rd_d;
  logic [0:2]        ld_ppp_q, ld_ppp_d;
  logic              tmr_clr, tmr_en, tmr_tc, tmr_err;

  wb_load_timer #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .en (tmr_en),
    .tc (tmr_tc),
    .err(tmr_err)
  );

  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    ppp_d    = ppp_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ld_wb_d  = ld_wb_q;
    ld_rd_d  = ld_rd_q;
    ld_ppp_d = ld_ppp_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (bus.mem_valid) begin
          if (bus.mem_is_load) begin
            ld_wb_d  = bus.mem_wb_en;
            ld_rd_d  = bus.mem_rd;
            ld_ppp_d = ppp_norm(bus.mem_ppp);
            tmr_clr  = 1'b1;
            state_d  = WB_WAIT_LOAD;
          end else begin
            wr_en_d = bus.mem_wb_en && (bus.mem_rd != '0);
            addr_d  = bus.mem_rd;
            data_d  = bus.mem_alu_data;
            ppp_d   = ppp_norm(bus.mem_ppp);
          end
        end
      end
      WB_WAIT_LOAD: begin
        // A response on the terminal cycle takes priority over the timeout.
        if (bus.dmem_rsp_valid) begin
          wr_en_d = ld_wb_q && (ld_rd_q != '0);
          addr_d  = ld_rd_q;
          data_d  = bus.dmem_rsp_data;
          ppp_d   = ld_ppp_q;
          state_d = WB_IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Stage boundary: register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_IDLE;
      wr_en_q <= 1'b0;
      ppp_q   <= PPP_FULL;
      addr_q  <= '0;
      data_q  <= '0;
      ld_wb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      ppp_q   <= ppp_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ld_wb_q <= ld_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    ld_rd_q  <= ld_rd_d;
    ld_ppp_q <= ld_ppp_d;
  end

  assign bus.stall_out   = (state_q == WB_WAIT_LOAD);
  assign bus.wr_en       = wr_en_q;
  assign bus.ppp         = ppp_q;
  assign bus.in_addr     = addr_q;
  assign bus.in_data     = data_q;
  assign bus.err_timeout = tmr_err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized bench for wb_stage against a transaction-level model.
module tb_wb_stage;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_stage #(.DATA_W(DW), .ADDR_W(AW), .LOAD_TIMEOUT(LT), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state: one outstanding load at most.
  bit          m_busy = 1'b0;
  int          m_waited = 0;
  bit          m_wb;
  logic [0:4]  m_rd;
  logic [0:2]  m_ppp;
  logic        e_wr = 1'b0;
  logic [0:2]  e_ppp = '0;
  logic [0:4]  e_addr = '0;
  logic [0:63] e_data = '0;
  logic        e_err = 1'b0;

  task automatic chk(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:2] norm(input logic [0:2] c);
    return (c >= 3'd5) ? 3'd0 : c;
  endfunction

  task automatic model(input bit r, input bit v, input bit we, input bit ld,
                       input logic [0:4] rd, input logic [0:2] pp, input logic [0:63] alu,
                       input bit rv, input logic [0:63] rdata);
    e_wr = 1'b0;
    if (r) begin
      m_busy = 1'b0; e_ppp = '0; e_addr = '0; e_data = '0; e_err = 1'b0;
    end else if (!m_busy) begin
      if (v && ld) begin
        m_busy = 1'b1; m_waited = 0; m_wb = we; m_rd = rd; m_ppp = norm(pp);
      end else if (v) begin
        e_wr = we && (rd != 5'd0); e_addr = rd; e_data = alu; e_ppp = norm(pp);
      end
    end else begin
      m_waited++;
      if (rv) begin
        e_wr = m_wb && (m_rd != 5'd0); e_addr = m_rd; e_data = rdata; e_ppp = m_ppp;
        m_busy = 1'b0;
      end else if (m_waited == LT) begin
        e_err = 1'b1; m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit we, input bit ld,
                      input logic [0:4] rd, input logic [0:2] pp, input logic [0:63] alu,
                      input bit rv, input logic [0:63] rdata);
    rst = r;
    bus.mem_valid = v; bus.mem_wb_en = we; bus.mem_is_load = ld; bus.mem_rd = rd;
    bus.mem_ppp = pp; bus.mem_alu_data = alu;
    bus.dmem_rsp_valid = rv; bus.dmem_rsp_data = rdata;
    model(r, v, we, ld, rd, pp, alu, rv, rdata);
    @(posedge clk);
    #1;
    chk("stall_out", 64'(bus.stall_out), 64'(m_busy));
    chk("wr_en", 64'(bus.wr_en), 64'(e_wr));
    chk("ppp", 64'(bus.ppp), 64'(e_ppp));
    chk("in_addr", 64'(bus.in_addr), 64'(e_addr));
    chk("in_data", bus.in_data, e_data);
    chk("err_timeout", 64'(bus.err_timeout), 64'(e_err));
  endtask

  task automatic idle(input bit rv = 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'd0, rv, 64'hDEAD_BEEF_0BAD_F00D);
  endtask

  initial begin
    int stall_cnt;
    bus.mem_valid = 1'b0; bus.mem_wb_en = 1'b0; bus.mem_is_load = 1'b0; bus.mem_rd = '0;
    bus.mem_ppp = '0; bus.mem_alu_data = '0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'd0, 1'b0, 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 3'd1, 64'h1234, 1'b1, 64'h5678);
    chk("reset_wr_en", 64'(bus.wr_en), 64'd0);

    // ALU op to r7, then idle holds data
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 3'b000, 64'h0123456789ABCDEF, 1'b0, 64'd0);
    chk("alu_data_fixed", bus.in_data, 64'h0123456789ABCDEF);
    idle();

    // Load to r3, ppp=010, response on 4th waiting cycle
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 3'b010, 64'hAAAA, 1'b0, 64'd0);
    idle(); idle(); idle();
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 3'd0, 64'h9999, 1'b1, 64'hFFFF0000AAAA5555);
    chk("load_data_fixed", bus.in_data, 64'hFFFF0000AAAA5555);
    chk("load_ppp_fixed", 64'(bus.ppp), 64'(3'b010));
    idle();

    // Writes to r0 suppressed, load to r0 still waits
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 64'h77, 1'b0, 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 3'd0, 64'h0, 1'b0, 64'd0);
    idle(); idle(1'b1); idle();

    // Load timeout: stall exactly LT cycles
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 3'd0, 64'h0, 1'b0, 64'd0);
    stall_cnt = int'(bus.stall_out);
    for (int i = 0; i < LT + 3; i++) begin
      idle();
      stall_cnt += int'(bus.stall_out);
    end
    chk("timeout_stall_cycles", 64'(stall_cnt), 64'(LT));
    chk("timeout_err_fixed", 64'(bus.err_timeout), 64'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 3'd0, 64'h5555, 1'b0, 64'd0);
    chk("after_timeout_wr", 64'(bus.wr_en), 64'd1);

    // Reset mid-wait with a simultaneous response
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 3'd1, 64'h0, 1'b0, 64'd0);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'd0, 1'b1, 64'hCAFE);
    idle(1'b1); idle();

    // ppp normalisation and spurious responses in IDLE
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 3'b110, 64'h4242, 1'b0, 64'd0);
    chk("ppp_norm_fixed", 64'(bus.ppp), 64'd0);
    idle(1'b1); idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 2) == 0), 5'($urandom), 3'($urandom),
           {32'($urandom), 32'($urandom)}, ($urandom_range(0, 3) == 0),
           {32'($urandom), 32'($urandom)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file write port.
- Registers MEM-stage results (ALU result or pending load) and drives the file's wr_en / ppp / in_addr / in_data with a one-cycle-registered interface.
- Owns the load-wait handshake with data memory: stalls upstream until load data returns, and flags load timeouts.

Parameters:
- DATA_W, 64, datapath width; must match the register file.
- ADDR_W, 5, register address width (32 registers).
- LOAD_TIMEOUT, 16, maximum cycles to wait in WAIT_LOAD before abandoning the load; must be >= 1.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > LOAD_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage presents an instruction this cycle.
- mem_wb_en  in  1  instruction writes a register.
- mem_is_load  in  1  result comes from data memory, not mem_alu_data.
- mem_rd  in  [0:ADDR_W-1]  destination register.
- mem_ppp  in  [0:2]  selective-write code (000 full, 001 upper word, 010 lower word, 011 even bytes, 100 odd bytes).
- mem_alu_data  in  [0:DATA_W-1]  ALU result for non-load instructions.
- dmem_rsp_valid  in  1  load data valid this cycle.
- dmem_rsp_data  in  [0:DATA_W-1]  load data.
- stall_out  out  1  upstream must hold its instruction; mem_valid is ignored while this is high.
- wr_en  out  1  register file write enable.
- ppp  out  [0:2]  register file selective-write code.
- in_addr  out  [0:ADDR_W-1]  register file write address.
- in_data  out  [0:DATA_W-1]  register file write data.
- err_timeout  out  1  sticky load-timeout flag.

All vectors use MSB-at-index-0 ordering [0:W-1].

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, counter=0.
  - wr_en=0, ppp=000, in_addr=0, in_data=0, err_timeout=0.
  - Overrides everything, including mid-WAIT_LOAD. A dmem response arriving in the reset cycle is dropped.
- stall_out is combinational: 1 iff state==WAIT_LOAD. It is 0 during reset.
- Two-state FSM, IDLE and WAIT_LOAD.
- IDLE, mem_valid=1, mem_is_load=0:
  - Next cycle: wr_en = mem_wb_en & (mem_rd != 0); in_addr=mem_rd; in_data=mem_alu_data; ppp=normalised mem_ppp.
  - Latency 1. Back-to-back acceptance every cycle.
- IDLE, mem_valid=1, mem_is_load=1:
  - Latch rd, ppp and the wb flag; enter WAIT_LOAD; counter=0.
  - Next cycle wr_en=0.
- IDLE, mem_valid=0: next cycle wr_en=0. in_addr, in_data and ppp hold their last values.
- dmem_rsp_valid in IDLE is spurious: ignored, with no effect on any output.
- WAIT_LOAD, dmem_rsp_valid=1:
  - Next cycle: wr_en = latched wb flag & (latched rd != 0); in_data=dmem_rsp_data; in_addr and ppp from latches.
  - Return to IDLE. The stall drops the same cycle wr_en rises.
- WAIT_LOAD, dmem_rsp_valid=0:
  - counter increments.
  - When the counter equals LOAD_TIMEOUT-1 (LOAD_TIMEOUT waiting cycles elapsed), the next edge sets err_timeout=1, returns to IDLE, and produces no writeback.
  - A response arriving on that same final cycle wins: the writeback occurs and err_timeout stays unchanged.
- err_timeout stays set until rst.
- ppp normalisation: codes 101, 110, 111 are output as 000.
- Writes to r0 never assert wr_en. Loads to r0 still wait for their response to keep the memory protocol aligned.
- wr_en is a single-cycle pulse per retired instruction. It is never asserted twice for one instruction.

Decomposition:
- Shared package `proc_pkg` holds:
  - PPP_FULL=3'b000, PPP_HI=3'b001, PPP_LO=3'b010, PPP_EVEN=3'b011, PPP_ODD=3'b100;
  - DATA_W and ADDR_W defaults;
  - FSM state encoding WB_IDLE=1'b0, WB_WAIT_LOAD=1'b1.
- One natural sub-module: `wb_load_timer`, holding the counter, terminal-count compare and sticky error bit, with clear/enable inputs.
- Everything else stays in wb_stage.

Test Plan:
- ALU op, mem_rd=7, ppp=000, mem_alu_data=0x0123456789ABCDEF -> next cycle: wr_en=1, in_addr=7, in_data=0x0123456789ABCDEF, stall_out=0.
- Load to rd=3, ppp=010; dmem_rsp_valid after 4 cycles with 0xFFFF0000AAAA5555:
  - stall_out=1 for 4 cycles, wr_en=0 throughout;
  - the cycle after the response: wr_en=1, in_addr=3, ppp=010, in_data=0xFFFF0000AAAA5555, stall_out=0.
- ALU op to rd=0 with mem_wb_en=1 -> wr_en stays 0. Load to rd=0 -> stall until the response, then wr_en=0.
- Load with no response, LOAD_TIMEOUT=16 -> stall_out high for exactly 16 cycles, then err_timeout=1 (stays set), wr_en=0. A subsequent ALU op to rd=5 still writes back normally.
- rst asserted on cycle 2 of WAIT_LOAD with a response in the same cycle -> next cycle: all outputs 0 and state IDLE. No writeback ever occurs for that load.
- mem_ppp=110 on an ALU op to rd=9 -> wr_en=1, ppp=000. Spurious dmem_rsp_valid in IDLE -> outputs unaffected.
